// File: rtl/spi_reg_ctrl.sv
// Command sequencer between an SPI byte shifter and a 32x8 register file.
// Define SPI_REG_BURST_EN to let command bit 5 select burst auto-increment.
module spi_reg_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_active,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_load,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [5:0]        byte_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR,
        RD,
        ERR
    } state_t;

    localparam logic [4:0] ADDR_MASK = 5'((32'd1 << ADDR_W) - 32'd1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                burst_q, burst_d;
    logic                done_q, done_d;
    logic                pf_q, pf_d;
    logic                req_q, req_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_load_q, tx_load_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic                busy_q, busy_d;
    logic [5:0]          byte_cnt_q, byte_cnt_d;

    logic                count_byte;
    logic                cmd_ok;
    logic [ADDR_W-1:0]   next_addr;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        burst_d     = burst_q;
        done_d      = done_q;
        pf_d        = 1'b0;
        req_d       = req_q;
        tx_data_d   = tx_data_q;
        tx_load_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        byte_cnt_d  = byte_cnt_q;
        count_byte  = 1'b0;
        next_addr   = addr_q;
        cmd_ok      = (rx_data[6] == 1'b0) && ((rx_data[4:0] & ~ADDR_MASK) == 5'd0);

        // Chip-select release beats everything, including a byte arriving on the same edge.
        if (!cs_active) begin
            state_d = IDLE;
            req_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = CMD;
                    byte_cnt_d = '0;
                    done_d     = 1'b0;
                    req_d      = 1'b0;
                end
                CMD: begin
                    if (rx_valid) begin
                        addr_d = rx_data[ADDR_W-1:0];
                        done_d = 1'b0;
`ifdef SPI_REG_BURST_EN
                        burst_d = rx_data[5];
`else
                        burst_d = 1'b0;
`endif
                        if (!cmd_ok) begin
                            state_d = ERR;
                        end else if (rx_data[7]) begin
                            state_d = WR;
                        end else begin
                            state_d    = RD;
                            mem_addr_d = rx_data[ADDR_W-1:0];
                            pf_d       = 1'b1;
                        end
                    end
                end
                WR: begin
                    if (rx_valid) begin
                        count_byte = 1'b1;
                        if (!done_q) begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = addr_q;
                            mem_wdata_d = rx_data;
                            if (burst_q) begin
                                addr_d = addr_q + ADDR_W'(1);
                            end else begin
                                done_d = 1'b1;
                            end
                        end
                    end
                end
                RD: begin
                    count_byte = rx_valid;
                    if (pf_q) begin
                        tx_data_d = mem_rdata;
                        tx_load_d = 1'b1;
                    end
                    // A dummy byte landing on a prefetch cycle is held over to the next cycle.
                    if (rx_valid || req_q) begin
                        if (pf_q) begin
                            req_d = 1'b1;
                        end else begin
                            req_d      = 1'b0;
                            next_addr  = burst_q ? addr_q + ADDR_W'(1) : addr_q;
                            addr_d     = next_addr;
                            mem_addr_d = next_addr;
                            pf_d       = 1'b1;
                        end
                    end
                end
                ERR: begin
                    count_byte = rx_valid;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (count_byte && (byte_cnt_q != 6'd63)) begin
            byte_cnt_d = byte_cnt_q + 6'd1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            burst_q     <= 1'b0;
            done_q      <= 1'b0;
            pf_q        <= 1'b0;
            req_q       <= 1'b0;
            tx_data_q   <= '0;
            tx_load_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            byte_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            burst_q     <= burst_d;
            done_q      <= done_d;
            pf_q        <= pf_d;
            req_q       <= req_d;
            tx_data_q   <= tx_data_d;
            tx_load_q   <= tx_load_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            busy_q      <= busy_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_load   = tx_load_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign busy      = busy_q;
    assign byte_cnt  = byte_cnt_q;

endmodule
